// File: rtl/salu_pkg.sv
// Shared SALU writeback types and widths for the SGPR write path.
package salu_pkg;
  localparam int SGPR_ADDR_W = 9;
  localparam int SGPR_DATA_W = 64;
  localparam int WFID_W      = 6;

  // One SGPR write: dword enables, register address, data, owning wavefront.
  typedef struct packed {
    logic [1:0]             en;
    logic [SGPR_ADDR_W-1:0] addr;
    logic [SGPR_DATA_W-1:0] data;
    logic [WFID_W-1:0]      wfid;
  } sgpr_wr_t;
endpackage

// File: rtl/sgpr_wr_arbiter_if.sv
// Bundle of the SALU writeback, LSU return, SGPR write port and status signals.
// Handshakes: a SALU write is a one-cycle salu_req pulse and is always taken
// (queued or, when full with no pop, dropped and flagged); an LSU write is
// lsu_req held with stable payload until lsu_grant is high in the same cycle.
interface sgpr_wr_arbiter_if;
  import salu_pkg::*;

  logic                   salu_req;
  logic [1:0]             salu_wr_en;
  logic [SGPR_ADDR_W-1:0] salu_wr_addr;
  logic [SGPR_DATA_W-1:0] salu_wr_data;
  logic [WFID_W-1:0]      salu_wfid;

  logic                   lsu_req;
  logic [1:0]             lsu_wr_en;
  logic [SGPR_ADDR_W-1:0] lsu_wr_addr;
  logic [SGPR_DATA_W-1:0] lsu_wr_data;
  logic [WFID_W-1:0]      lsu_wfid;
  logic                   lsu_grant;

  logic [1:0]             sgpr_wr_en;
  logic [SGPR_ADDR_W-1:0] sgpr_wr_addr;
  logic [SGPR_DATA_W-1:0] sgpr_wr_data;
  logic                   salu_instr_done;
  logic                   lsu_instr_done;
  logic [WFID_W-1:0]      done_wfid;
  logic                   salu_buf_full;
  logic                   salu_overflow;

  modport master (
    output salu_req, salu_wr_en, salu_wr_addr, salu_wr_data, salu_wfid,
    output lsu_req, lsu_wr_en, lsu_wr_addr, lsu_wr_data, lsu_wfid,
    input  lsu_grant,
    input  sgpr_wr_en, sgpr_wr_addr, sgpr_wr_data,
    input  salu_instr_done, lsu_instr_done, done_wfid,
    input  salu_buf_full, salu_overflow
  );

  modport slave (
    input  salu_req, salu_wr_en, salu_wr_addr, salu_wr_data, salu_wfid,
    input  lsu_req, lsu_wr_en, lsu_wr_addr, lsu_wr_data, lsu_wfid,
    output lsu_grant,
    output sgpr_wr_en, sgpr_wr_addr, sgpr_wr_data,
    output salu_instr_done, lsu_instr_done, done_wfid,
    output salu_buf_full, salu_overflow
  );
endinterface

// File: rtl/sgpr_wr_fifo.sv
// Synchronous FIFO of SGPR writes. Pointers carry one extra wrap bit so that
// full (MSB differs, low bits equal) and empty (equal) are distinguishable.
// A push while full is accepted only when a pop happens in the same cycle.
module sgpr_wr_fifo
  import salu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  sgpr_wr_t wr_data,
  output sgpr_wr_t rd_data,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  sgpr_wr_t    mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; wraps naturally modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/sgpr_wr_arbiter.sv
// Arbitrates the single SGPR write port between queued SALU writebacks and
// the LSU return path. LSU normally wins, but the SALU queue is served once
// it has lost STARVE_MAX consecutive cycles while non-empty.
module sgpr_wr_arbiter
  import salu_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input logic              clk,
  input logic              rst,
  sgpr_wr_arbiter_if.slave bus
);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  sgpr_wr_t        salu_in;
  sgpr_wr_t        salu_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            grant_salu;
  logic            grant_lsu;
  logic            at_limit;
  logic [SW-1:0]   starve_cnt;
  sgpr_wr_t        out_q;
  logic            salu_done_q;
  logic            lsu_done_q;
  logic            overflow_q;

  assign salu_in = '{en: bus.salu_wr_en, addr: bus.salu_wr_addr,
                     data: bus.salu_wr_data, wfid: bus.salu_wfid};

  sgpr_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.salu_req),
    .pop     (grant_salu),
    .wr_data (salu_in),
    .rd_data (salu_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // One grant per cycle; nothing is granted while reset is held.
  always_comb begin
    at_limit   = (starve_cnt == STARVE_LIM);
    grant_salu = 1'b0;
    grant_lsu  = 1'b0;
    if (rst) begin
      grant_salu = !fifo_empty && (!bus.lsu_req || at_limit);
      grant_lsu  = bus.lsu_req && !grant_salu;
    end
  end

  // Count consecutive SALU losses; saturates at the limit.
  always_ff @(posedge clk) begin
    if (!rst || fifo_empty || grant_salu) starve_cnt <= '0;
    else if (grant_lsu && !at_limit)      starve_cnt <= starve_cnt + 1'b1;
  end

  // Sticky flag for a SALU push that found the queue full with no pop.
  always_ff @(posedge clk) begin
    if (!rst)                                           overflow_q <= 1'b0;
    else if (bus.salu_req && fifo_full && !grant_salu)  overflow_q <= 1'b1;
  end

  // Registered SGPR write port and retire pulses for the granted source.
  always_ff @(posedge clk) begin
    if (!rst || (!grant_salu && !grant_lsu)) begin
      out_q       <= '0;
      salu_done_q <= 1'b0;
      lsu_done_q  <= 1'b0;
    end else if (grant_salu) begin
      out_q       <= salu_head;
      salu_done_q <= 1'b1;
      lsu_done_q  <= 1'b0;
    end else begin
      out_q       <= '{en: bus.lsu_wr_en, addr: bus.lsu_wr_addr,
                       data: bus.lsu_wr_data, wfid: bus.lsu_wfid};
      salu_done_q <= 1'b0;
      lsu_done_q  <= 1'b1;
    end
  end

  assign bus.lsu_grant       = grant_lsu;
  assign bus.sgpr_wr_en      = out_q.en;
  assign bus.sgpr_wr_addr    = out_q.addr;
  assign bus.sgpr_wr_data    = out_q.data;
  assign bus.done_wfid       = out_q.wfid;
  assign bus.salu_instr_done = salu_done_q;
  assign bus.lsu_instr_done  = lsu_done_q;
  assign bus.salu_buf_full   = fifo_full;
  assign bus.salu_overflow   = overflow_q;
endmodule

// File: tb/tb_sgpr_wr_arbiter.sv
// Directed bench for sgpr_wr_arbiter (DEPTH=4, STARVE_MAX=3).
// Inputs change 1 time unit after each rising edge; outputs are sampled on
// the falling edge. "Cycle c" runs from rising edge c to rising edge c+1.
module tb_sgpr_wr_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [80:0] exp_q[$];

  sgpr_wr_arbiter_if bus ();

  sgpr_wr_arbiter #(.DEPTH(4), .STARVE_MAX(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic cyc_begin();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_sample();
    @(negedge clk);
  endtask

  task automatic drive_salu(input logic req, input logic [1:0] en, input logic [8:0] addr,
                            input logic [63:0] data, input logic [5:0] wfid);
    bus.salu_req     = req;
    bus.salu_wr_en   = en;
    bus.salu_wr_addr = addr;
    bus.salu_wr_data = data;
    bus.salu_wfid    = wfid;
  endtask

  task automatic drive_lsu(input logic req, input logic [1:0] en, input logic [8:0] addr,
                           input logic [63:0] data, input logic [5:0] wfid);
    bus.lsu_req     = req;
    bus.lsu_wr_en   = en;
    bus.lsu_wr_addr = addr;
    bus.lsu_wr_data = data;
    bus.lsu_wfid    = wfid;
  endtask

  task automatic drive_idle();
    drive_salu(1'b0, 2'b00, 9'h0, 64'h0, 6'h0);
    drive_lsu(1'b0, 2'b00, 9'h0, 64'h0, 6'h0);
  endtask

  // Reset state, with both requesters active while reset is held
  task automatic test_reset();
    rst = 1'b0;
    drive_salu(1'b1, 2'b11, 9'h001, 64'h1, 6'h01);
    drive_lsu(1'b1, 2'b11, 9'h002, 64'h2, 6'h02);
    repeat (2) begin
      cyc_begin();
      cyc_sample();
    end
    checks++; if (bus.lsu_grant !== 1'b0) begin failures++; $display("FAIL reset_lsu_grant got=%0b exp=0", bus.lsu_grant); end
    checks++; if (bus.sgpr_wr_en !== 2'b00) begin failures++; $display("FAIL reset_wr_en got=%b exp=00", bus.sgpr_wr_en); end
    checks++; if (bus.sgpr_wr_addr !== 9'h0) begin failures++; $display("FAIL reset_addr got=%h exp=000", bus.sgpr_wr_addr); end
    checks++; if (bus.sgpr_wr_data !== 64'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.sgpr_wr_data); end
    checks++; if (bus.salu_instr_done !== 1'b0 || bus.lsu_instr_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b%0b exp=00", bus.salu_instr_done, bus.lsu_instr_done); end
    checks++; if (bus.done_wfid !== 6'h0) begin failures++; $display("FAIL reset_wfid got=%h exp=00", bus.done_wfid); end
    checks++; if (bus.salu_buf_full !== 1'b0 || bus.salu_overflow !== 1'b0) begin failures++; $display("FAIL reset_status full=%0b ovf=%0b exp=0 0", bus.salu_buf_full, bus.salu_overflow); end
    cyc_begin();
    rst = 1'b1;
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      cyc_sample();
      checks++; if (bus.salu_instr_done !== 1'b0) begin failures++; $display("FAIL reset_no_queued_push cycle=%0d got=%0b exp=0", c, bus.salu_instr_done); end
      cyc_begin();
    end
  endtask

  // Lone SALU write: visible two edges after the request, for one cycle
  task automatic test_salu_alone();
    drive_salu(1'b1, 2'b11, 9'h012, 64'hDEAD_BEEF_0123_4567, 6'd5);
    cyc_sample();
    checks++; if (bus.sgpr_wr_en !== 2'b00) begin failures++; $display("FAIL salu_c0_wr_en got=%b exp=00", bus.sgpr_wr_en); end
    cyc_begin();
    drive_idle();
    cyc_sample();
    checks++; if (bus.sgpr_wr_en !== 2'b00 || bus.salu_instr_done !== 1'b0) begin failures++; $display("FAIL salu_c1_no_bypass en=%b done=%0b exp=00 0", bus.sgpr_wr_en, bus.salu_instr_done); end
    cyc_begin();
    cyc_sample();
    checks++; if (bus.sgpr_wr_en !== 2'b11) begin failures++; $display("FAIL salu_c2_wr_en got=%b exp=11", bus.sgpr_wr_en); end
    checks++; if (bus.sgpr_wr_addr !== 9'h012) begin failures++; $display("FAIL salu_c2_addr got=%h exp=012", bus.sgpr_wr_addr); end
    checks++; if (bus.sgpr_wr_data !== 64'hDEAD_BEEF_0123_4567) begin failures++; $display("FAIL salu_c2_data got=%h exp=deadbeef01234567", bus.sgpr_wr_data); end
    checks++; if (bus.salu_instr_done !== 1'b1 || bus.lsu_instr_done !== 1'b0) begin failures++; $display("FAIL salu_c2_done got=%0b%0b exp=10", bus.salu_instr_done, bus.lsu_instr_done); end
    checks++; if (bus.done_wfid !== 6'd5) begin failures++; $display("FAIL salu_c2_wfid got=%0d exp=5", bus.done_wfid); end
    cyc_begin();
    cyc_sample();
    checks++; if (bus.salu_instr_done !== 1'b0 || bus.sgpr_wr_en !== 2'b00) begin failures++; $display("FAIL salu_c3_one_shot done=%0b en=%b exp=0 00", bus.salu_instr_done, bus.sgpr_wr_en); end
    cyc_begin();
  endtask

  // Lone LSU write: combinational grant, write after the next edge
  task automatic test_lsu_alone();
    drive_lsu(1'b1, 2'b01, 9'h1A5, 64'h0000_1111_2222_3333, 6'd42);
    cyc_sample();
    checks++; if (bus.lsu_grant !== 1'b1) begin failures++; $display("FAIL lsu_grant got=%0b exp=1", bus.lsu_grant); end
    cyc_begin();
    drive_idle();
    cyc_sample();
    checks++; if (bus.lsu_grant !== 1'b0) begin failures++; $display("FAIL lsu_grant_drop got=%0b exp=0", bus.lsu_grant); end
    checks++; if (bus.sgpr_wr_en !== 2'b01 || bus.sgpr_wr_addr !== 9'h1A5) begin failures++; $display("FAIL lsu_write en=%b addr=%h exp=01 1a5", bus.sgpr_wr_en, bus.sgpr_wr_addr); end
    checks++; if (bus.sgpr_wr_data !== 64'h0000_1111_2222_3333) begin failures++; $display("FAIL lsu_data got=%h exp=0000111122223333", bus.sgpr_wr_data); end
    checks++; if (bus.lsu_instr_done !== 1'b1 || bus.salu_instr_done !== 1'b0 || bus.done_wfid !== 6'd42) begin failures++; $display("FAIL lsu_done lsu=%0b salu=%0b wfid=%0d exp=1 0 42", bus.lsu_instr_done, bus.salu_instr_done, bus.done_wfid); end
    cyc_begin();
    cyc_sample();
    checks++; if (bus.lsu_instr_done !== 1'b0) begin failures++; $display("FAIL lsu_one_shot got=%0b exp=0", bus.lsu_instr_done); end
    cyc_begin();
  endtask

  // SALU entry with no dword enables still retires with a done pulse
  task automatic test_en00();
    drive_salu(1'b1, 2'b00, 9'h033, 64'h5555_AAAA_5555_AAAA, 6'd17);
    cyc_begin();
    drive_idle();
    cyc_begin();
    cyc_sample();
    checks++; if (bus.salu_instr_done !== 1'b1 || bus.done_wfid !== 6'd17) begin failures++; $display("FAIL en00_done done=%0b wfid=%0d exp=1 17", bus.salu_instr_done, bus.done_wfid); end
    checks++; if (bus.sgpr_wr_en !== 2'b00) begin failures++; $display("FAIL en00_wr_en got=%b exp=00", bus.sgpr_wr_en); end
    cyc_begin();
  endtask

  function automatic logic starve_gnt(int c);
    return (c >= 1) && (c <= 10) && (c != 4);
  endfunction

  // One queued SALU write against a continuous LSU stream
  task automatic test_starvation();
    for (int c = 0; c < 12; c++) begin
      if (c == 0) drive_salu(1'b1, 2'b10, 9'h0C0, 64'hCAFE_F00D_0000_0007, 6'd9);
      else        drive_salu(1'b0, 2'b00, 9'h0, 64'h0, 6'h0);
      drive_lsu((c >= 1) && (c <= 10), 2'b11, 9'h0AA, 64'h7777_7777_7777_7777, 6'd3);
      cyc_sample();
      checks++; if (bus.lsu_grant !== starve_gnt(c)) begin failures++; $display("FAIL starve_lsu_grant cycle=%0d got=%0b exp=%0b", c, bus.lsu_grant, starve_gnt(c)); end
      checks++; if (bus.salu_instr_done !== (c == 5)) begin failures++; $display("FAIL starve_salu_done cycle=%0d got=%0b exp=%0b", c, bus.salu_instr_done, (c == 5)); end
      checks++; if (bus.lsu_instr_done !== starve_gnt(c - 1)) begin failures++; $display("FAIL starve_lsu_done cycle=%0d got=%0b exp=%0b", c, bus.lsu_instr_done, starve_gnt(c - 1)); end
      if (c == 5) begin
        checks++; if (bus.sgpr_wr_data !== 64'hCAFE_F00D_0000_0007 || bus.sgpr_wr_en !== 2'b10) begin failures++; $display("FAIL starve_salu_write data=%h en=%b exp=cafef00d00000007 10", bus.sgpr_wr_data, bus.sgpr_wr_en); end
      end
      cyc_begin();
    end
    drive_idle();
  endtask

  // Six back-to-back pushes under LSU pressure: fill, full push+pop, drop
  task automatic test_overflow_full();
    logic [80:0] obs;
    logic [5:0]  gnt_mask;
    int          retired;
    gnt_mask = 6'b101111;
    retired  = 0;
    for (int c = 0; c < 13; c++) begin
      drive_salu(c < 6, 2'b11, 9'(9'h100 + c), 64'hA5A5_0000_0000_0000 + 64'(c), 6'(10 + c));
      drive_lsu(c < 6, 2'b01, 9'h1F0, 64'h1234_5678_9ABC_DEF0, 6'd33);
      if (c < 5) exp_q.push_back({2'b11, 9'(9'h100 + c), 64'hA5A5_0000_0000_0000 + 64'(c), 6'(10 + c)});
      cyc_sample();
      checks++; if (bus.lsu_grant !== ((c < 6) ? gnt_mask[c] : 1'b0)) begin failures++; $display("FAIL ovf_lsu_grant cycle=%0d got=%0b", c, bus.lsu_grant); end
      checks++; if (bus.salu_buf_full !== (c >= 4 && c <= 6)) begin failures++; $display("FAIL ovf_buf_full cycle=%0d got=%0b exp=%0b", c, bus.salu_buf_full, (c >= 4 && c <= 6)); end
      checks++; if (bus.salu_overflow !== (c >= 6)) begin failures++; $display("FAIL ovf_sticky cycle=%0d got=%0b exp=%0b", c, bus.salu_overflow, (c >= 6)); end
      checks++; if (bus.salu_instr_done !== (c == 5 || (c >= 7 && c <= 10))) begin failures++; $display("FAIL ovf_salu_done cycle=%0d got=%0b", c, bus.salu_instr_done); end
      if (bus.salu_instr_done === 1'b1) begin
        obs = {bus.sgpr_wr_en, bus.sgpr_wr_addr, bus.sgpr_wr_data, bus.done_wfid};
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL ovf_extra_retire cycle=%0d got=%h exp=none", c, obs);
        end else begin
          if (obs !== exp_q[0]) begin failures++; $display("FAIL ovf_order cycle=%0d got=%h exp=%h", c, obs, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        retired++;
      end
      cyc_begin();
    end
    drive_idle();
    checks++; if (retired != 5 || exp_q.size() != 0) begin failures++; $display("FAIL ovf_retire_count got=%0d left=%0d exp=5 0", retired, exp_q.size()); end
    exp_q.delete();
  endtask

  // Reset with three writes queued discards them silently
  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      drive_salu(1'b1, 2'b11, 9'(9'h050 + c), 64'hBBBB_0000_0000_0000 + 64'(c), 6'(20 + c));
      drive_lsu(1'b1, 2'b11, 9'h060, 64'hEEEE_EEEE_EEEE_EEEE, 6'd1);
      cyc_begin();
    end
    drive_salu(1'b0, 2'b00, 9'h0, 64'h0, 6'h0);
    rst = 1'b0;
    cyc_sample();
    checks++; if (bus.lsu_grant !== 1'b0) begin failures++; $display("FAIL rstmid_grant_gated got=%0b exp=0", bus.lsu_grant); end
    cyc_begin();
    rst = 1'b1;
    drive_idle();
    cyc_sample();
    checks++; if (bus.sgpr_wr_en !== 2'b00 || bus.sgpr_wr_addr !== 9'h0 || bus.sgpr_wr_data !== 64'h0 || bus.done_wfid !== 6'h0) begin failures++; $display("FAIL rstmid_port en=%b addr=%h data=%h wfid=%h exp=0", bus.sgpr_wr_en, bus.sgpr_wr_addr, bus.sgpr_wr_data, bus.done_wfid); end
    checks++; if (bus.salu_instr_done !== 1'b0 || bus.lsu_instr_done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%0b%0b exp=00", bus.salu_instr_done, bus.lsu_instr_done); end
    checks++; if (bus.salu_buf_full !== 1'b0 || bus.salu_overflow !== 1'b0) begin failures++; $display("FAIL rstmid_status full=%0b ovf=%0b exp=0 0", bus.salu_buf_full, bus.salu_overflow); end
    for (int c = 0; c < 5; c++) begin
      cyc_begin();
      cyc_sample();
      checks++; if (bus.salu_instr_done !== 1'b0 || bus.sgpr_wr_en !== 2'b00) begin failures++; $display("FAIL rstmid_no_retire cycle=%0d done=%0b en=%b exp=0 00", c, bus.salu_instr_done, bus.sgpr_wr_en); end
    end
    cyc_begin();
  endtask

  // Sequence and final report
  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    drive_idle();
    test_reset();
    test_salu_alone();
    test_lsu_alone();
    test_en00();
    test_starvation();
    test_overflow_full();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
